grf_mp_scoreboard: RTL and testbench

//  Next-generation general register file: parametrised width/depth, NUM_RD combinational read

---
 rtl/grf_mp_scoreboard.sv | 120 ++++++++++++
 tb/tb_grf_mp_scoreboard.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_mp_scoreboard.sv
// General register file with NUM_RD combinational read ports, two write ports (W1 wins on
// collision), same-cycle write-through bypass and a per-register busy scoreboard.
module grf_mp_scoreboard #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int NUM_RD = 2,
   parameter int TRACE  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   output logic [NUM_RD-1:0]    rd_busy,
   input  logic                 we0,
   input  logic [AW-1:0]        waddr0,
   input  logic [DW-1:0]        wdata0,
   input  logic [31:0]          wpc0,
   input  logic                 we1,
   input  logic [AW-1:0]        waddr1,
   input  logic [DW-1:0]        wdata1,
   input  logic [31:0]          wpc1,
   input  logic                 issue_en,
   input  logic [AW-1:0]        issue_addr,
   input  logic                 flush,
   output logic [(1<<AW)-1:0]   busy_vec
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0]    r_gpr [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busyNext;
   logic             w_commit0;
   logic             w_commit1;

   // Port 0 is dropped entirely when port 1 commits to the same register.
   always_comb begin
      w_commit1 = we1 && (waddr1 != '0);
      w_commit0 = we0 && (waddr0 != '0) && !(w_commit1 && (waddr1 == waddr0));
   end

   // Later assignments win: write-clear, then flush, then issue-set.
   always_comb begin
      w_busyNext = r_busy;
      if (w_commit1) begin
         w_busyNext[waddr1] = 1'b0;
      end
      if (w_commit0) begin
         w_busyNext[waddr0] = 1'b0;
      end
      if (flush) begin
         w_busyNext = '0;
      end
      if (issue_en && (issue_addr != '0)) begin
         w_busyNext[issue_addr] = 1'b1;
      end
      w_busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busyNext;
      end
   end

   // The write log lives here so both lines share one edge, port 0 first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_gpr[i] <= '0;
         end
      end else begin
         if (w_commit0) begin
            r_gpr[waddr0] <= wdata0;
         end
         if (w_commit1) begin
            r_gpr[waddr1] <= wdata1;
         end
`ifndef SYNTHESIS
         if (TRACE != 0) begin
            if (w_commit0) begin
               $display("%d@%h: $%d <= %h", $time, wpc0, waddr0, wdata0);
            end
            if (w_commit1) begin
               $display("%d@%h: $%d <= %h", $time, wpc1, waddr1, wdata1);
            end
         end
`endif
      end
   end

   // Reads bypass committing writes (port 1 first); reset forces every port to zero.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         logic [AW-1:0] w_rdAddr;
         logic          w_hit0;
         logic          w_hit1;
         w_rdAddr = rd_addr[k*AW +: AW];
         w_hit1   = w_commit1 && (waddr1 == w_rdAddr);
         w_hit0   = w_commit0 && (waddr0 == w_rdAddr);
         if (!reset && (w_rdAddr != '0)) begin
            if (w_hit1) begin
               rd_data[k*DW +: DW] = wdata1;
            end else if (w_hit0) begin
               rd_data[k*DW +: DW] = wdata0;
            end else begin
               rd_data[k*DW +: DW] = r_gpr[w_rdAddr];
            end
            rd_busy[k] = r_busy[w_rdAddr] & ~(w_hit0 | w_hit1);
         end
      end
   end

   assign busy_vec = r_busy;

endmodule

// File: tb/tb_grf_mp_scoreboard.sv
// Directed bench for grf_mp_scoreboard: reset, bypass, collisions, r0, scoreboard and flush.
module tb_grf_mp_scoreboard;

   logic        clk;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        we0;
   logic [4:0]  waddr0;
   logic [31:0] wdata0;
   logic [31:0] wpc0;
   logic        we1;
   logic [4:0]  waddr1;
   logic [31:0] wdata1;
   logic [31:0] wpc1;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic        flush;
   logic [31:0] busy_vec;

   int checks;
   int errors;

   grf_mp_scoreboard #(.DW(32), .AW(5), .NUM_RD(2), .TRACE(1)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wpc0(wpc0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wpc1(wpc1),
      .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .busy_vec(busy_vec)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs;
      we0 = 1'b0; waddr0 = '0; wdata0 = '0; wpc0 = '0;
      we1 = 1'b0; waddr1 = '0; wdata1 = '0; wpc1 = '0;
      issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
   endtask

   task automatic test_reset;
      idleInputs();
      reset   = 1'b1;
      rd_addr = {5'd0, 5'd5};
      #2;
      checks++;
      if (busy_vec !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_busy: got %h expected %h", busy_vec, 32'h0);
      end
      checks++;
      if (rd_data !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_rd_data: got %h expected %h", rd_data, 64'h0);
      end
      tick();
      reset = 1'b0;
      tick();
      // Reset pulse between edges after r5 is written and r3 is busy.
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; wpc0 = 32'h100;
      issue_en = 1'b1; issue_addr = 5'd3;
      tick();
      idleInputs();
      #1;
      checks++;
      if (rd_data[31:0] !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL r5_before_reset: got %h expected %h", rd_data[31:0], 32'hDEADBEEF);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h0) begin
         errors++;
         $display("[TB] FAIL r5_mid_reset: got %h expected %h", rd_data[31:0], 32'h0);
      end
      checks++;
      if (busy_vec !== 32'h0) begin
         errors++;
         $display("[TB] FAIL busy_mid_reset: got %h expected %h", busy_vec, 32'h0);
      end
      // A write presented across an edge during reset must be discarded.
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h12345678;
      tick();
      idleInputs();
      reset = 1'b0;
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h0) begin
         errors++;
         $display("[TB] FAIL r5_after_reset: got %h expected %h", rd_data[31:0], 32'h0);
      end
   endtask

   task automatic test_bypass;
      tick();
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11; wpc0 = 32'h200;
      rd_addr = {5'd0, 5'd3};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h11) begin
         errors++;
         $display("[TB] FAIL bypass_same_cycle: got %h expected %h", rd_data[31:0], 32'h11);
      end
      tick();
      idleInputs();
      rd_addr = {5'd3, 5'd0};
      #1;
      checks++;
      if (rd_data !== {32'h11, 32'h0}) begin
         errors++;
         $display("[TB] FAIL bypass_stored: got %h expected %h", rd_data, {32'h11, 32'h0});
      end
   endtask

   task automatic test_collision;
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hA; wpc0 = 32'h300;
      we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hB; wpc1 = 32'h304;
      rd_addr = {5'd7, 5'd7};
      #1;
      checks++;
      if (rd_data !== {32'hB, 32'hB}) begin
         errors++;
         $display("[TB] FAIL collision_bypass: got %h expected %h", rd_data, {32'hB, 32'hB});
      end
      tick();
      // Both ports to different registers commit together.
      we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h22; wpc0 = 32'h308;
      we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h33; wpc1 = 32'h30C;
      tick();
      idleInputs();
      #1;
      checks++;
      if (rd_data[31:0] !== 32'hB) begin
         errors++;
         $display("[TB] FAIL collision_r7: got %h expected %h", rd_data[31:0], 32'hB);
      end
      rd_addr = {5'd9, 5'd8};
      #1;
      checks++;
      if (rd_data !== {32'h33, 32'h22}) begin
         errors++;
         $display("[TB] FAIL dual_write: got %h expected %h", rd_data, {32'h33, 32'h22});
      end
   endtask

   task automatic test_r0;
      we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF; wpc1 = 32'h400;
      issue_en = 1'b1; issue_addr = 5'd0;
      rd_addr = {5'd0, 5'd0};
      #1;
      checks++;
      if (rd_data !== 64'h0) begin
         errors++;
         $display("[TB] FAIL r0_bypass: got %h expected %h", rd_data, 64'h0);
      end
      tick();
      idleInputs();
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL r0_read: got %h/%b expected 0/00", rd_data, rd_busy);
      end
      checks++;
      if (busy_vec !== 32'h0) begin
         errors++;
         $display("[TB] FAIL r0_busy: got %h expected %h", busy_vec, 32'h0);
      end
   endtask

   task automatic test_scoreboard;
      rd_addr = {5'd0, 5'd9};
      issue_en = 1'b1; issue_addr = 5'd9;
      #1;
      checks++;
      if (rd_busy !== 2'b00) begin
         errors++;
         $display("[TB] FAIL sb_issue_same_cycle: got %b expected %b", rd_busy, 2'b00);
      end
      tick();
      idleInputs();
      #1;
      checks++;
      if (rd_busy !== 2'b01 || busy_vec !== 32'h200) begin
         errors++;
         $display("[TB] FAIL sb_busy_set: got %b/%h expected 01/%h", rd_busy, busy_vec, 32'h200);
      end
      tick();
      issue_en = 1'b1; issue_addr = 5'd9;
      we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99; wpc0 = 32'h500;
      #1;
      checks++;
      if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h99) begin
         errors++;
         $display("[TB] FAIL sb_issue_write: got %b/%h expected 00/%h", rd_busy, rd_data[31:0], 32'h99);
      end
      tick();
      idleInputs();
      #1;
      checks++;
      if (rd_busy !== 2'b01 || busy_vec !== 32'h200) begin
         errors++;
         $display("[TB] FAIL sb_stays_busy: got %b/%h expected 01/%h", rd_busy, busy_vec, 32'h200);
      end
      we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h5A; wpc1 = 32'h504;
      #1;
      checks++;
      if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h5A) begin
         errors++;
         $display("[TB] FAIL sb_write_bypass: got %b/%h expected 00/%h", rd_busy, rd_data[31:0], 32'h5A);
      end
      tick();
      idleInputs();
      #1;
      checks++;
      if (busy_vec !== 32'h0) begin
         errors++;
         $display("[TB] FAIL sb_cleared: got %h expected %h", busy_vec, 32'h0);
      end
   endtask

   task automatic test_flush;
      logic [4:0] regs [3];
      regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd4;
      for (int i = 0; i < 3; i++) begin
         issue_en = 1'b1; issue_addr = regs[i];
         tick();
      end
      idleInputs();
      #1;
      checks++;
      if (busy_vec !== 32'h16) begin
         errors++;
         $display("[TB] FAIL flush_setup: got %h expected %h", busy_vec, 32'h16);
      end
      flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd6;
      tick();
      idleInputs();
      #1;
      checks++;
      if (busy_vec !== 32'h40) begin
         errors++;
         $display("[TB] FAIL flush_issue: got %h expected %h", busy_vec, 32'h40);
      end
      rd_addr = {5'd6, 5'd4};
      #1;
      checks++;
      if (rd_busy !== 2'b10) begin
         errors++;
         $display("[TB] FAIL flush_rd_busy: got %b expected %b", rd_busy, 2'b10);
      end
      flush = 1'b1;
      tick();
      idleInputs();
      #1;
      checks++;
      if (busy_vec !== 32'h0) begin
         errors++;
         $display("[TB] FAIL flush_all: got %h expected %h", busy_vec, 32'h0);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp [4];
      exp[0] = 32'hC0DE_0010; exp[1] = 32'hC0DE_0011;
      exp[2] = 32'hC0DE_0012; exp[3] = 32'hC0DE_0013;
      for (int i = 0; i < 2; i++) begin
         we0 = 1'b1; waddr0 = 5'(10 + 2*i); wdata0 = exp[2*i];     wpc0 = 32'h600 + 32'(8*i);
         we1 = 1'b1; waddr1 = 5'(11 + 2*i); wdata1 = exp[2*i + 1]; wpc1 = 32'h604 + 32'(8*i);
         tick();
      end
      idleInputs();
      for (int i = 0; i < 2; i++) begin
         rd_addr = {5'(11 + 2*i), 5'(10 + 2*i)};
         #1;
         checks++;
         if (rd_data !== {exp[2*i + 1], exp[2*i]}) begin
            errors++;
            $display("[TB] FAIL b2b_pair%0d: got %h expected %h", i, rd_data, {exp[2*i + 1], exp[2*i]});
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_bypass();
      test_collision();
      test_r0();
      test_scoreboard();
      test_flush();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
